// File: rtl/regfile_sb.sv
// Two-read, two-write integer register file with a per-register busy scoreboard.
// Write ports clear busy bits and reservations set them; x0 is hardwired to zero.
module regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic            wb0_en,
  input  logic [AW-1:0]   wb0_rd,
  input  logic [XLEN-1:0] wb0_data,
  input  logic            wb1_en,
  input  logic [AW-1:0]   wb1_rd,
  input  logic [XLEN-1:0] wb1_data,
  output logic [AW:0]     busy_count
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      count_q, count_d;

  logic wb0_act, wb1_act;
  assign wb0_act = wb0_en && (wb0_rd != '0);
  assign wb1_act = wb1_en && (wb1_rd != '0);

  // Next state: load port applied after ALU port so it wins a same-rd collision;
  // a reservation is applied last so a new producer outlives a same-cycle clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wb0_act) begin
      regs_d[wb0_rd] = wb0_data;
      busy_d[wb0_rd] = 1'b0;
    end
    if (wb1_act) begin
      regs_d[wb1_rd] = wb1_data;
      busy_d[wb1_rd] = 1'b0;
    end
    if (issue_en && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // Population count of the post-edge busy vector.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      count_d = count_d + (AW+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_count = count_q;

  // Read port 1: stored value, optionally overridden by this cycle's writeback.
  always_comb begin
    rs1_data = regs_q[rs1];
    rs1_busy = busy_q[rs1];
    if (BYPASS != 0) begin
      if (wb0_act && (wb0_rd == rs1)) begin
        rs1_data = wb0_data;
        rs1_busy = 1'b0;
      end
      if (wb1_act && (wb1_rd == rs1)) begin
        rs1_data = wb1_data;
        rs1_busy = 1'b0;
      end
    end
    if (rst) begin
      rs1_data = '0;
    end
  end

  always_comb begin
    rs2_data = regs_q[rs2];
    rs2_busy = busy_q[rs2];
    if (BYPASS != 0) begin
      if (wb0_act && (wb0_rd == rs2)) begin
        rs2_data = wb0_data;
        rs2_busy = 1'b0;
      end
      if (wb1_act && (wb1_rd == rs2)) begin
        rs2_data = wb1_data;
        rs2_busy = 1'b0;
      end
    end
    if (rst) begin
      rs2_data = '0;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: bypassing and non-bypassing 32x32 instances
// share stimulus; a 64-bit, 16-entry instance covers the parameter sweep.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus for the two 32x32 instances
  logic [4:0]  rs1, rs2, issue_rd, wb0_rd, wb1_rd;
  logic        issue_en, wb0_en, wb1_en;
  logic [31:0] wb0_data, wb1_data;

  logic [31:0] a_rs1_data, a_rs2_data, b_rs1_data, b_rs2_data;
  logic        a_rs1_busy, a_rs2_busy, b_rs1_busy, b_rs2_busy;
  logic [5:0]  a_count, b_count;

  // 64-bit, 16-entry instance
  logic [3:0]  c_rs1, c_rs2, c_issue_rd, c_wb0_rd, c_wb1_rd;
  logic        c_issue_en, c_wb0_en, c_wb1_en;
  logic [63:0] c_wb0_data, c_wb1_data, c_rs1_data, c_rs2_data;
  logic        c_rs1_busy, c_rs2_busy;
  logic [4:0]  c_count;

  int total  = 0;
  int passed = 0;

  regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
    .rs1_data(a_rs1_data), .rs2_data(a_rs2_data),
    .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .wb0_en(wb0_en), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
    .busy_count(a_count)
  );

  regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
    .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .wb0_en(wb0_en), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
    .busy_count(b_count)
  );

  regfile_sb #(.XLEN(64), .NREGS(16), .BYPASS(1)) u_c (
    .clk(clk), .rst(rst), .rs1(c_rs1), .rs2(c_rs2),
    .rs1_data(c_rs1_data), .rs2_data(c_rs2_data),
    .rs1_busy(c_rs1_busy), .rs2_busy(c_rs2_busy),
    .issue_en(c_issue_en), .issue_rd(c_issue_rd),
    .wb0_en(c_wb0_en), .wb0_rd(c_wb0_rd), .wb0_data(c_wb0_data),
    .wb1_en(c_wb1_en), .wb1_rd(c_wb1_rd), .wb1_data(c_wb1_data),
    .busy_count(c_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_en = 1'b0; issue_rd = '0;
    wb0_en = 1'b0; wb0_rd = '0; wb0_data = '0;
    wb1_en = 1'b0; wb1_rd = '0; wb1_data = '0;
    c_issue_en = 1'b0; c_issue_rd = '0;
    c_wb0_en = 1'b0; c_wb0_rd = '0; c_wb0_data = '0;
    c_wb1_en = 1'b0; c_wb1_rd = '0; c_wb1_data = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rs1 = '0; rs2 = '0; c_rs1 = '0; c_rs2 = '0;
    repeat (2) tick();
    check("reset_count", 64'(a_count), 64'd0);
    check("reset_rs1_data", 64'(a_rs1_data), 64'd0);
    rst = 1'b0;

    // Reset mid-operation
    wb0_en = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hDEADBEEF;
    issue_en = 1'b1; issue_rd = 5'd6;
    tick();
    idle();
    rs1 = 5'd5; rs2 = 5'd6;
    #1;
    check("pre_rst_x5", 64'(a_rs1_data), 64'hDEADBEEF);
    check("pre_rst_x6_busy", 64'(a_rs2_busy), 64'd1);
    check("pre_rst_count", 64'(a_count), 64'd1);
    wb1_en = 1'b1; wb1_rd = 5'd5; wb1_data = 32'h77;
    issue_en = 1'b1; issue_rd = 5'd6;
    rst = 1'b1;
    #1;
    check("rst_async_x5", 64'(a_rs1_data), 64'd0);
    check("rst_async_x6_busy", 64'(a_rs2_busy), 64'd0);
    check("rst_async_count", 64'(a_count), 64'd0);
    check("rst_async_b_x5", 64'(b_rs1_data), 64'd0);
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("post_rst_x5", 64'(a_rs1_data), 64'd0);
    check("post_rst_x6_busy", 64'(a_rs2_busy), 64'd0);
    check("post_rst_count", 64'(a_count), 64'd0);

    // x0 guard
    wb0_en = 1'b1; wb0_rd = 5'd0; wb0_data = 32'h1234;
    wb1_en = 1'b1; wb1_rd = 5'd0; wb1_data = 32'h5678;
    issue_en = 1'b1; issue_rd = 5'd0;
    rs1 = 5'd0;
    #1;
    check("x0_bypass_data", 64'(a_rs1_data), 64'd0);
    check("x0_bypass_busy", 64'(a_rs1_busy), 64'd0);
    tick();
    idle();
    #1;
    check("x0_data", 64'(a_rs1_data), 64'd0);
    check("x0_busy", 64'(b_rs1_busy), 64'd0);
    check("x0_count", 64'(a_count), 64'd0);

    // Dual write collision
    wb0_en = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h11;
    wb1_en = 1'b1; wb1_rd = 5'd3; wb1_data = 32'h22;
    rs1 = 5'd3;
    #1;
    check("dual_bypass_a", 64'(a_rs1_data), 64'h22);
    check("dual_nobypass_b", 64'(b_rs1_data), 64'h0);
    tick();
    idle();
    #1;
    check("dual_a", 64'(a_rs1_data), 64'h22);
    check("dual_b", 64'(b_rs1_data), 64'h22);

    // Scoreboard
    issue_en = 1'b1; issue_rd = 5'd7;
    rs2 = 5'd7;
    #1;
    check("issue_same_cycle_busy", 64'(a_rs2_busy), 64'd0);
    tick();
    idle();
    #1;
    check("sb_busy_a", 64'(a_rs2_busy), 64'd1);
    check("sb_busy_b", 64'(b_rs2_busy), 64'd1);
    check("sb_count", 64'(a_count), 64'd1);
    wb0_en = 1'b1; wb0_rd = 5'd7; wb0_data = 32'h55;
    #1;
    check("sb_wb_busy_a", 64'(a_rs2_busy), 64'd0);
    check("sb_wb_busy_b", 64'(b_rs2_busy), 64'd1);
    check("sb_wb_data_a", 64'(a_rs2_data), 64'h55);
    check("sb_wb_data_b", 64'(b_rs2_data), 64'h0);
    tick();
    idle();
    #1;
    check("sb_clear_count", 64'(a_count), 64'd0);
    check("sb_clear_count_b", 64'(b_count), 64'd0);
    check("sb_data_b", 64'(b_rs2_data), 64'h55);

    // Reserve/clear race
    issue_en = 1'b1; issue_rd = 5'd9;
    rs1 = 5'd9;
    tick();
    idle();
    #1;
    check("race_pre_busy", 64'(a_rs1_busy), 64'd1);
    check("race_pre_count", 64'(a_count), 64'd1);
    issue_en = 1'b1; issue_rd = 5'd9;
    wb1_en = 1'b1; wb1_rd = 5'd9; wb1_data = 32'hAB;
    #1;
    check("race_same_busy_a", 64'(a_rs1_busy), 64'd0);
    check("race_same_busy_b", 64'(b_rs1_busy), 64'd1);
    check("race_same_data_a", 64'(a_rs1_data), 64'hAB);
    tick();
    idle();
    #1;
    check("race_data_a", 64'(a_rs1_data), 64'hAB);
    check("race_data_b", 64'(b_rs1_data), 64'hAB);
    check("race_busy", 64'(a_rs1_busy), 64'd1);
    check("race_count", 64'(a_count), 64'd1);

    // Re-reserving a busy register keeps a single count
    issue_en = 1'b1; issue_rd = 5'd9;
    tick();
    idle();
    #1;
    check("rereserve_count", 64'(a_count), 64'd1);

    // Parameter sweep: 64-bit data, 16 registers
    c_wb0_en = 1'b1; c_wb0_rd = 4'd15; c_wb0_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    idle();
    c_rs1 = 4'd15;
    #1;
    check("c_x15_data", c_rs1_data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("c_count_zero", 64'(c_count), 64'd0);
    for (int i = 1; i < 16; i++) begin
      c_issue_en = 1'b1; c_issue_rd = 4'(i);
      tick();
    end
    idle();
    c_rs2 = 4'd1;
    #1;
    check("c_count_full", 64'(c_count), 64'd15);
    check("c_x15_busy", 64'(c_rs1_busy), 64'd1);
    check("c_x1_busy", 64'(c_rs2_busy), 64'd1);
    check("a_count_untouched", 64'(a_count), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
